// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer defaults, per-step pulse masks and the
// NRx2 envelope register layout used by every channel's envelope unit.
package apu_pkg;

    localparam int FS_DIV_DEFAULT = 8192;
    localparam int LEN_MAX        = 64;

    // Bit n set means the pulse fires when step n executes.
    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

    typedef struct packed {
        logic [3:0] vol;
        logic       dir;
        logic [2:0] period;
    } env_cfg_t;

endpackage

// File: rtl/apu_envelope_m.sv
// Volume envelope unit: period timer plus saturating volume stepper.
// A trigger reloads volume and timer and wins over a same-cycle envelope clock.
module apu_envelope_m
    import apu_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       trigger_i,
    input  logic       env_clk_i,
    input  env_cfg_t   cfg_i,
    output logic [3:0] volume_o
);

    logic [3:0] timer_q, timer_d;
    logic [3:0] vol_q, vol_d;

    always_comb begin
        timer_d = timer_q;
        vol_d   = vol_q;
        if (trigger_i) begin
            vol_d   = cfg_i.vol;
            timer_d = (cfg_i.period == 3'd0) ? 4'd8 : {1'b0, cfg_i.period};
        end else if (env_clk_i && cfg_i.period != 3'd0) begin
            // A timer of 0 (never triggered) is treated like an expiry.
            if (timer_q <= 4'd1) begin
                timer_d = {1'b0, cfg_i.period};
                if (cfg_i.dir && vol_q != 4'd15) begin
                    vol_d = vol_q + 4'd1;
                end else if (!cfg_i.dir && vol_q != 4'd0) begin
                    vol_d = vol_q - 4'd1;
                end
            end else begin
                timer_d = timer_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            timer_q <= 4'd0;
            vol_q   <= 4'd0;
        end else begin
            timer_q <= timer_d;
            vol_q   <= vol_d;
        end
    end

    assign volume_o = vol_q;

endmodule

// File: rtl/apu_ch2_sequencer_m.sv
// Frame sequencer (512 Hz step pulses) plus channel-2 trigger, length and envelope control.
// Optional macro APU_LEN_EXTRA_CLK_EN adds the DMG extra length clock on a len_enable rise.
module apu_ch2_sequencer_m #(
    parameter int FS_DIV  = apu_pkg::FS_DIV_DEFAULT,
    parameter int LEN_MAX = apu_pkg::LEN_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gb_tick,
    input  logic       apu_on,
    input  logic       len_load,
    input  logic [5:0] len_data,
    input  logic       len_enable,
    input  logic       trigger,
    input  logic [7:0] env_cfg,
    output logic [2:0] frame_step,
    output logic       len_clk,
    output logic       sweep_clk,
    output logic       env_clk,
    output logic       ch_active,
    output logic [3:0] ch_volume,
    output logic       dac_en
);
    import apu_pkg::*;

    localparam int            DW         = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(FS_DIV - 1);
    localparam logic [6:0]    LEN_RELOAD = 7'(LEN_MAX);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    step_q, step_d;
    logic          len_clk_q, len_clk_d;
    logic          sweep_clk_q, sweep_clk_d;
    logic          env_clk_q, env_clk_d;
    logic [6:0]    len_cnt_q, len_cnt_d;
    logic [6:0]    len_base, len_mid;
    logic          active_q, active_d;
    logic          seq_clr;

    assign seq_clr = rst || !apu_on;
    assign dac_en  = (env_cfg[7:3] != 5'd0);

    always_comb begin
        div_d       = div_q;
        step_d      = step_q;
        len_clk_d   = 1'b0;
        sweep_clk_d = 1'b0;
        env_clk_d   = 1'b0;
        if (gb_tick) begin
            if (div_q == DIV_LAST) begin
                div_d       = '0;
                step_d      = step_q + 3'd1;
                len_clk_d   = LEN_STEPS[step_d];
                sweep_clk_d = SWEEP_STEPS[step_d];
                env_clk_d   = ENV_STEPS[step_d];
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

`ifdef APU_LEN_EXTRA_CLK_EN
    logic len_en_q;
    logic extra_zero;

    always_ff @(posedge clk) begin
        if (seq_clr) len_en_q <= 1'b0;
        else         len_en_q <= len_enable;
    end
`endif

    // A fresh len_load value is the starting point for every other length action.
    assign len_base = len_load ? (7'd64 - {1'b0, len_data}) : len_cnt_q;

    always_comb begin
        len_mid  = len_base;
        active_d = active_q;
`ifdef APU_LEN_EXTRA_CLK_EN
        extra_zero = 1'b0;
        if (len_enable && !len_en_q && !step_q[0] && len_base != 7'd0) begin
            len_mid    = len_base - 7'd1;
            extra_zero = (len_mid == 7'd0);
        end
        if (extra_zero && !trigger) active_d = 1'b0;
`endif
        len_cnt_d = len_mid;
        if (trigger) begin
            active_d = dac_en;
            if (len_mid == 7'd0) len_cnt_d = LEN_RELOAD;
        end else if (len_clk_q && !len_load && len_enable && len_mid != 7'd0) begin
            len_cnt_d = len_mid - 7'd1;
            if (len_cnt_d == 7'd0) active_d = 1'b0;
        end
        if (!dac_en) active_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (seq_clr) begin
            div_q       <= '0;
            step_q      <= 3'd7;
            len_clk_q   <= 1'b0;
            sweep_clk_q <= 1'b0;
            env_clk_q   <= 1'b0;
            len_cnt_q   <= 7'd0;
            active_q    <= 1'b0;
        end else begin
            div_q       <= div_d;
            step_q      <= step_d;
            len_clk_q   <= len_clk_d;
            sweep_clk_q <= sweep_clk_d;
            env_clk_q   <= env_clk_d;
            len_cnt_q   <= len_cnt_d;
            active_q    <= active_d;
        end
    end

    apu_envelope_m u_env (
        .clk_i     (clk),
        .clr_i     (seq_clr),
        .trigger_i (trigger),
        .env_clk_i (env_clk_q),
        .cfg_i     (env_cfg_t'(env_cfg)),
        .volume_o  (ch_volume)
    );

    assign frame_step = step_q;
    assign len_clk    = len_clk_q;
    assign sweep_clk  = sweep_clk_q;
    assign env_clk    = env_clk_q;
    assign ch_active  = active_q;

endmodule

// File: tb/tb_apu_ch2_sequencer_m.sv
// Directed bench for apu_ch2_sequencer_m with a fast frame sequencer (FS_DIV = 4).
// Honours APU_LEN_EXTRA_CLK_EN for the len_enable edge case.
module tb_apu_ch2_sequencer_m;

    localparam int FS_DIV = 4;

    logic       clk = 1'b0;
    logic       rst, gb_tick, apu_on, len_load, len_enable, trigger;
    logic [5:0] len_data;
    logic [7:0] env_cfg;
    logic [2:0] frame_step;
    logic       len_clk, sweep_clk, env_clk, ch_active, dac_en;
    logic [3:0] ch_volume;

    int n_checks = 0;
    int n_pass   = 0;

    apu_ch2_sequencer_m #(.FS_DIV(FS_DIV), .LEN_MAX(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .gb_tick    (gb_tick),
        .apu_on     (apu_on),
        .len_load   (len_load),
        .len_data   (len_data),
        .len_enable (len_enable),
        .trigger    (trigger),
        .env_cfg    (env_cfg),
        .frame_step (frame_step),
        .len_clk    (len_clk),
        .sweep_clk  (sweep_clk),
        .env_clk    (env_clk),
        .ch_active  (ch_active),
        .ch_volume  (ch_volume),
        .dac_en     (dac_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stops on the cycle where the selected pulse is visible (0 = len_clk, 1 = env_clk).
    task automatic wait_sig(input int sel, input int budget, output int cycles);
        bit done;
        done   = 1'b0;
        cycles = 0;
        while (!done && cycles < budget) begin
            if ((sel == 0 && len_clk) || (sel == 1 && env_clk)) done = 1'b1;
            else begin
                cyc();
                cycles++;
            end
        end
        if (!done) check("wait_timeout", 0, 1);
    endtask

    task automatic do_trigger();
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_step, cycles;
        rst = 1'b1; gb_tick = 1'b1; apu_on = 1'b1; len_load = 1'b0;
        len_data = 6'd0; len_enable = 1'b0; trigger = 1'b0; env_cfg = 8'h00;
        cyc(2);
        check("rst_step", frame_step, 7);
        check("rst_len_clk", len_clk, 0);
        check("rst_env_clk", env_clk, 0);
        check("rst_active", ch_active, 0);
        check("rst_volume", ch_volume, 0);
        check("rst_len_cnt", dut.len_cnt_q, 0);
        rst = 1'b0;

        // Step sequence: with a tick every cycle, the k-th edge wraps when k % 4 == 0.
        for (int k = 1; k <= 40; k++) begin
            cyc();
            exp_step = (k < 4) ? 7 : ((k / 4 - 1) % 8);
            check("seq_step", frame_step, exp_step);
            check("seq_len_clk", len_clk, (k % 4 == 0) && (exp_step % 2 == 0));
            check("seq_sweep_clk", sweep_clk, (k % 4 == 0) && (exp_step == 2 || exp_step == 6));
            check("seq_env_clk", env_clk, (k % 4 == 0) && (exp_step == 7));
        end

        // Length expiry with load and trigger in the same cycle.
        len_enable = 1'b1;
        cyc();
        env_cfg = 8'hF0; len_data = 6'd62; len_load = 1'b1; trigger = 1'b1;
        cyc();
        len_load = 1'b0; trigger = 1'b0;
        check("len_trig_active", ch_active, 1);
        check("len_trig_volume", ch_volume, 15);
        check("len_trig_cnt", dut.len_cnt_q, 2);
        wait_sig(0, 40, cycles);
        cyc();
        check("len_after1_active", ch_active, 1);
        check("len_after1_cnt", dut.len_cnt_q, 1);
        wait_sig(0, 40, cycles);
        cyc();
        check("len_after2_active", ch_active, 0);
        check("len_after2_cnt", dut.len_cnt_q, 0);

        // Envelope up, period 3, saturating at 15.
        len_enable = 1'b0;
        env_cfg = 8'h0B;
        do_trigger();
        check("env_up_start", ch_volume, 0);
        check("env_up_active", ch_active, 1);
        for (int k = 1; k <= 48; k++) begin
            wait_sig(1, 100, cycles);
            cyc();
            check("env_up_vol", ch_volume, ((k / 3) > 15) ? 15 : (k / 3));
        end

        // Envelope down, period 1, saturating at 0.
        env_cfg = 8'hF1;
        do_trigger();
        check("env_dn_start", ch_volume, 15);
        for (int k = 1; k <= 17; k++) begin
            wait_sig(1, 100, cycles);
            cyc();
            check("env_dn_vol", ch_volume, (k >= 15) ? 0 : (15 - k));
        end

        // DAC gating.
        env_cfg = 8'h07;
        #1;
        check("dac_off", dac_en, 0);
        cyc();
        check("dac_off_active", ch_active, 0);
        env_cfg = 8'h08;
        #1;
        check("dac_on_dir", dac_en, 1);
        cyc(3);
        check("dac_on_no_trig", ch_active, 0);
        do_trigger();
        check("dac_on_trig", ch_active, 1);

        // apu_on drop with volume 9, then restart timing.
        env_cfg = 8'h90;
        do_trigger();
        check("off_pre_vol", ch_volume, 9);
        apu_on = 1'b0;
        cyc();
        check("off_vol", ch_volume, 0);
        check("off_active", ch_active, 0);
        check("off_step", frame_step, 7);
        check("off_len_cnt", dut.len_cnt_q, 0);
        trigger = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("off_no_pulse", {len_clk, sweep_clk, env_clk}, 0);
            check("off_hold_step", frame_step, 7);
        end
        trigger = 1'b0;
        check("off_ignored_trig", ch_active, 0);
        apu_on = 1'b1;
        wait_sig(0, 40, cycles);
        check("on_first_len_latency", cycles, FS_DIV);
        check("on_first_step", frame_step, 0);

        // Trigger with counter 0 in the same cycle as a length clock.
        trigger = 1'b1; len_enable = 1'b1;
        cyc();
        trigger = 1'b0;
        check("trig_len_cnt", dut.len_cnt_q, 64);
        check("trig_len_active", ch_active, 1);

        // len_enable rising edge while at step 0.
        len_enable = 1'b0;
        len_data = 6'd59; len_load = 1'b1;
        cyc();
        len_load = 1'b0;
        check("extra_load_cnt", dut.len_cnt_q, 5);
        for (int k = 0; k < 8; k++) begin
            wait_sig(0, 40, cycles);
            if (frame_step == 3'd0) break;
            cyc();
        end
        check("extra_at_step0", frame_step, 0);
        cyc();
        len_enable = 1'b1;
        cyc();
`ifdef APU_LEN_EXTRA_CLK_EN
        check("extra_cnt", dut.len_cnt_q, 4);
`else
        check("extra_cnt", dut.len_cnt_q, 5);
`endif
        check("extra_active", ch_active, 1);

        // Mid-run reset.
        rst = 1'b1;
        cyc();
        check("midrst_step", frame_step, 7);
        check("midrst_vol", ch_volume, 0);
        check("midrst_active", ch_active, 0);
        check("midrst_len_cnt", dut.len_cnt_q, 0);
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
